// File: rtl/pass_scheduler.sv
// pass_scheduler: walks a layer as nested tile loops (oc outer, row middle,
// ic inner) and issues one pass per tile, waiting for pass_done_i between
// passes. Optional build macro PASS_SCHED_PERF_EN adds pass/busy-cycle
// performance counters.
//
// state   | meaning
// IDLE    | waiting for layer_start_i
// ISSUE   | pass_start_o pulse for the current tile
// WAIT    | pass in flight, waiting for pass_done_i
// ADVANCE | step to the next tile, or finish after the last one
// DONE    | layer_done_o pulse, then back to IDLE
module pass_scheduler #(
  parameter int IDX_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             layer_start_i,
  input  logic [IDX_W-1:0] cfg_num_oc_tile_i,
  input  logic [IDX_W-1:0] cfg_num_row_tile_i,
  input  logic [IDX_W-1:0] cfg_num_ic_tile_i,
  input  logic             pass_done_i,
  output logic             pass_start_o,
  output logic [IDX_W-1:0] oc_idx_o,
  output logic [IDX_W-1:0] row_idx_o,
  output logic [IDX_W-1:0] ic_idx_o,
  output logic             first_ic_o,
  output logic             last_ic_o,
  output logic             busy_o,
  output logic             layer_done_o
`ifdef PASS_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_pass_cnt_o,
  output logic [CNT_W-1:0] perf_cycle_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ADVANCE,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] num_oc_q, num_row_q, num_ic_q;
  logic [IDX_W-1:0] oc_q, row_q, ic_q;
  logic             cfg_zero, empty, ic_last, row_last, oc_last, last_tile;
  logic             start_ok;

  assign cfg_zero  = (cfg_num_oc_tile_i == '0) || (cfg_num_row_tile_i == '0) ||
                     (cfg_num_ic_tile_i == '0);
  assign empty     = (num_oc_q == '0) || (num_row_q == '0) || (num_ic_q == '0);
  assign ic_last   = (ic_q  == num_ic_q  - IDX_ONE);
  assign row_last  = (row_q == num_row_q - IDX_ONE);
  assign oc_last   = (oc_q  == num_oc_q  - IDX_ONE);
  assign last_tile = oc_last && row_last && ic_last;
  assign start_ok  = (state_q == IDLE) && layer_start_i;

  assign oc_idx_o  = oc_q;
  assign row_idx_o = row_q;
  assign ic_idx_o  = ic_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and pulse/flag outputs. An empty sweep goes through ADVANCE
  // so layer_done lands two cycles after the start, like any sweep end.
  always_comb begin
    state_d      = state_q;
    pass_start_o = 1'b0;
    layer_done_o = 1'b0;
    busy_o       = (state_q != IDLE);
    first_ic_o   = 1'b0;
    last_ic_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (layer_start_i) state_d = cfg_zero ? ADVANCE : ISSUE;
      end
      ISSUE: begin
        pass_start_o = 1'b1;
        first_ic_o   = (ic_q == '0);
        last_ic_o    = ic_last;
        state_d      = WAIT;
      end
      WAIT: begin
        first_ic_o = (ic_q == '0);
        last_ic_o  = ic_last;
        if (pass_done_i) state_d = ADVANCE;
      end
      ADVANCE: begin
        first_ic_o = !empty && (ic_q == '0);
        last_ic_o  = !empty && ic_last;
        state_d    = (empty || last_tile) ? DONE : ISSUE;
      end
      DONE: begin
        layer_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch tile counts at sweep start and step indices ic -> row -> oc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_oc_q  <= '0;
      num_row_q <= '0;
      num_ic_q  <= '0;
      oc_q      <= '0;
      row_q     <= '0;
      ic_q      <= '0;
    end else if (start_ok) begin
      num_oc_q  <= cfg_num_oc_tile_i;
      num_row_q <= cfg_num_row_tile_i;
      num_ic_q  <= cfg_num_ic_tile_i;
      oc_q      <= '0;
      row_q     <= '0;
      ic_q      <= '0;
    end else if (state_q == ADVANCE && !empty && !last_tile) begin
      if (!ic_last) begin
        ic_q <= ic_q + IDX_ONE;
      end else begin
        ic_q <= '0;
        if (!row_last) begin
          row_q <= row_q + IDX_ONE;
        end else begin
          row_q <= '0;
          oc_q  <= oc_q + IDX_ONE;
        end
      end
    end
  end

`ifdef PASS_SCHED_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Saturating pass and busy-cycle counters, cleared when a sweep starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_pass_cnt_o  <= '0;
      perf_cycle_cnt_o <= '0;
    end else if (start_ok) begin
      perf_pass_cnt_o  <= '0;
      perf_cycle_cnt_o <= '0;
    end else begin
      if (state_q == ISSUE && perf_pass_cnt_o != '1)
        perf_pass_cnt_o <= perf_pass_cnt_o + CNT_ONE;
      if (state_q != IDLE && perf_cycle_cnt_o != '1)
        perf_cycle_cnt_o <= perf_cycle_cnt_o + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pass_scheduler.sv
// Bench for pass_scheduler: a timeline/tile-queue model predicts every
// output each cycle; directed sweeps pin the model with literal values.
module tb_pass_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       layer_start_i = 1'b0;
  logic [7:0] cfg_num_oc_tile_i = '0, cfg_num_row_tile_i = '0, cfg_num_ic_tile_i = '0;
  logic       pass_done_i = 1'b0;
  logic       pass_start_o, first_ic_o, last_ic_o, busy_o, layer_done_o;
  logic [7:0] oc_idx_o, row_idx_o, ic_idx_o;
`ifdef PASS_SCHED_PERF_EN
  logic [31:0] perf_pass_cnt_o, perf_cycle_cnt_o;
`endif

  pass_scheduler #(.IDX_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .layer_start_i(layer_start_i),
    .cfg_num_oc_tile_i(cfg_num_oc_tile_i), .cfg_num_row_tile_i(cfg_num_row_tile_i),
    .cfg_num_ic_tile_i(cfg_num_ic_tile_i), .pass_done_i(pass_done_i),
    .pass_start_o(pass_start_o), .oc_idx_o(oc_idx_o), .row_idx_o(row_idx_o),
    .ic_idx_o(ic_idx_o), .first_ic_o(first_ic_o), .last_ic_o(last_ic_o),
    .busy_o(busy_o), .layer_done_o(layer_done_o)
`ifdef PASS_SCHED_PERF_EN
    , .perf_pass_cnt_o(perf_pass_cnt_o), .perf_cycle_cnt_o(perf_cycle_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Behavioural model: list of tiles still to run plus predicted event cycles.
  int  q_oc[$], q_row[$], q_ic[$];
  int  m_issue_at = -1, m_done_at = -1, m_nic = 0;
  bit  m_active = 0, m_waiting = 0;
  longint m_pcnt = 0, m_ccnt = 0;

  // Model update from the inputs sampled at each rising edge.
  always @(posedge clk) begin
    int p;
    p = cyc;
    if (rst) begin
      q_oc.delete(); q_row.delete(); q_ic.delete();
      m_issue_at = -1; m_done_at = -1; m_active = 0; m_waiting = 0;
      m_pcnt = 0; m_ccnt = 0;
    end else begin
      if (!m_active && layer_start_i) begin
        m_pcnt = 0; m_ccnt = 0;
      end else if (m_active) begin
        m_ccnt++;
        if (p == m_issue_at) m_pcnt++;
      end
      if (m_waiting && pass_done_i) begin
        void'(q_oc.pop_front()); void'(q_row.pop_front()); void'(q_ic.pop_front());
        m_waiting = 0;
        if (q_oc.size() == 0) m_done_at = p + 2;
        else                  m_issue_at = p + 2;
      end
      if (p == m_issue_at) m_waiting = 1;
      if (!m_active && layer_start_i) begin
        m_active = 1;
        m_nic = int'(cfg_num_ic_tile_i);
        if (cfg_num_oc_tile_i == 0 || cfg_num_row_tile_i == 0 || cfg_num_ic_tile_i == 0) begin
          m_done_at = p + 2;
        end else begin
          for (int o = 0; o < int'(cfg_num_oc_tile_i); o++)
            for (int r = 0; r < int'(cfg_num_row_tile_i); r++)
              for (int i = 0; i < int'(cfg_num_ic_tile_i); i++) begin
                q_oc.push_back(o); q_row.push_back(r); q_ic.push_back(i);
              end
          m_issue_at = p + 1;
        end
      end
      if (m_active && p == m_done_at) m_active = 0;
    end
    cyc++;
  end

  // Logs used by the directed checks.
  int ps_oc[$], ps_row[$], ps_ic[$], ps_first[$], ps_last[$], ps_cyc[$], ld_cyc[$], bz_cyc[$];

  task automatic clear_logs();
    ps_oc.delete(); ps_row.delete(); ps_ic.delete(); ps_first.delete();
    ps_last.delete(); ps_cyc.delete(); ld_cyc.delete(); bz_cyc.delete();
  endtask

  // Compare DUT against the model on every cycle out of reset.
  always @(negedge clk) begin
    bit exp_ps;
    if (!rst && cyc > 0) begin
      exp_ps = (cyc == m_issue_at);
      check("pass_start", pass_start_o, exp_ps);
      check("layer_done", layer_done_o, cyc == m_done_at);
      check("busy", busy_o, m_active);
      if ((exp_ps || m_waiting) && q_oc.size() > 0) begin
        check("oc_idx", oc_idx_o, q_oc[0]);
        check("row_idx", row_idx_o, q_row[0]);
        check("ic_idx", ic_idx_o, q_ic[0]);
        check("first_ic", first_ic_o, q_ic[0] == 0);
        check("last_ic", last_ic_o, q_ic[0] == m_nic - 1);
      end
`ifdef PASS_SCHED_PERF_EN
      check("perf_pass", perf_pass_cnt_o, m_pcnt);
      check("perf_cycle", perf_cycle_cnt_o, m_ccnt);
`endif
      if (pass_start_o) begin
        ps_oc.push_back(oc_idx_o); ps_row.push_back(row_idx_o); ps_ic.push_back(ic_idx_o);
        ps_first.push_back(first_ic_o); ps_last.push_back(last_ic_o); ps_cyc.push_back(cyc);
      end
      if (layer_done_o) ld_cyc.push_back(cyc);
      if (busy_o) bz_cyc.push_back(cyc);
    end
  end

  // Stimulus driver: one cycle per call, auto-answering passes after a delay.
  int cd = 0, dly_fixed = 1;
  bit spur_all = 0, rnd_mode = 0;
  logic [7:0] c_oc = 0, c_row = 0, c_ic = 0;

  task automatic tick(input bit start);
    @(negedge clk); #1;
    pass_done_i = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) pass_done_i = 1'b1;
    end else if (rnd_mode && ($urandom % 10 == 0)) begin
      pass_done_i = 1'b1;
    end
    layer_start_i = start;
    if (pass_start_o) begin
      cd = (dly_fixed > 0) ? dly_fixed : int'($urandom_range(1, 4));
      if (spur_all || (rnd_mode && ($urandom % 4 == 0))) begin
        pass_done_i = 1'b1;
        layer_start_i = 1'b1;
      end
    end
    cfg_num_oc_tile_i = c_oc; cfg_num_row_tile_i = c_row; cfg_num_ic_tile_i = c_ic;
  endtask

  task automatic run_until_done(input int limit);
    for (int i = 0; i < limit && ld_cyc.size() == 0; i++) tick(1'b0);
    check("layer_done_seen", ld_cyc.size(), 1);
    tick(1'b0); tick(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; cd = 0; pass_done_i = 1'b0; layer_start_i = 1'b0;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_pass_start", pass_start_o, 0);
    check("rst_layer_done", layer_done_o, 0);
    check("rst_idx", {oc_idx_o, row_idx_o, ic_idx_o}, 0);
    check("rst_flags", {first_ic_o, last_ic_o}, 0);
`ifdef PASS_SCHED_PERF_EN
    check("rst_perf", perf_pass_cnt_o + perf_cycle_cnt_o, 0);
`endif
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic start_sweep(input int o, input int r, input int i, output int n);
    c_oc = 8'(o); c_row = 8'(r); c_ic = 8'(i);
    clear_logs();
    tick(1'b1);
    n = cyc;
  endtask

  initial begin
    int n;
    int e_oc[6] = '{0, 0, 0, 1, 1, 1};
    int e_ic[6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    tick(1'b0);

    // 2x1x3 sweep, done 5 cycles after each start.
    dly_fixed = 5;
    start_sweep(2, 1, 3, n);
    run_until_done(200);
    check("s1_npass", ps_oc.size(), 6);
    for (int k = 0; k < 6 && k < ps_oc.size(); k++) begin
      check("s1_oc", ps_oc[k], e_oc[k]);
      check("s1_ic", ps_ic[k], e_ic[k]);
      check("s1_first", ps_first[k], e_ic[k] == 0);
      check("s1_last", ps_last[k], e_ic[k] == 2);
    end

    // 1x1x1 latency.
    dly_fixed = 1;
    start_sweep(1, 1, 1, n);
    run_until_done(50);
    check("s2_start_cyc", (ps_cyc.size() > 0) ? ps_cyc[0] : -1, n + 1);
    check("s2_done_cyc", (ld_cyc.size() > 0) ? ld_cyc[0] : -1, n + 4);
    check("s2_busy_len", bz_cyc.size(), 4);
    check("s2_busy_first", (bz_cyc.size() > 0) ? bz_cyc[0] : -1, n + 1);

    // Zero row count: no pass.
    start_sweep(3, 0, 4, n);
    run_until_done(50);
    check("s3_npass", ps_oc.size(), 0);
    check("s3_done_cyc", (ld_cyc.size() > 0) ? ld_cyc[0] : -1, n + 2);

    // Spurious start/done during ISSUE.
    dly_fixed = 2; spur_all = 1;
    start_sweep(1, 2, 2, n);
    run_until_done(100);
    spur_all = 0;
    check("s4_npass", ps_oc.size(), 4);

    // Reset during the 3rd WAIT of a 2x2x2 sweep, then restart.
    dly_fixed = 3;
    start_sweep(2, 2, 2, n);
    for (int i = 0; i < 100 && ps_oc.size() < 3; i++) tick(1'b0);
    check("s5_reached_3rd", ps_oc.size(), 3);
    do_reset();
    start_sweep(2, 2, 2, n);
    run_until_done(200);
    check("s5_npass", ps_oc.size(), 8);
    check("s5_first_tile", (ps_oc.size() > 0) ? {ps_oc[0], ps_row[0], ps_ic[0]} : -1, 0);
`ifdef PASS_SCHED_PERF_EN
    check("s5_perf_pass", perf_pass_cnt_o, 8);
    check("s5_perf_cycle", perf_cycle_cnt_o, 41);
`endif

    // Maximum count on the inner loop.
    dly_fixed = 1;
    start_sweep(1, 1, 255, n);
    run_until_done(2000);
    check("s6_npass", ps_oc.size(), 255);
    check("s6_last_ic", (ps_ic.size() > 0) ? ps_ic[ps_ic.size()-1] : -1, 254);
    check("s6_last_flag", (ps_last.size() > 0) ? ps_last[ps_last.size()-1] : -1, 1);

    // Randomized traffic with config churn, stray pulses and rare resets.
    dly_fixed = 0; rnd_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 40 == 0) begin
        c_oc = 1; c_row = 1; c_ic = 8'($urandom_range(100, 255));
      end else begin
        c_oc = 8'($urandom_range(0, 3)); c_row = 8'($urandom_range(0, 3));
        c_ic = 8'($urandom_range(0, 3));
      end
      if ($urandom % 700 == 0) do_reset();
      else tick($urandom % 6 == 0);
    end
    rnd_mode = 0;
    clear_logs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
